// File: rtl/snake_pkg.sv
// Shared definitions for the snake motion engine: one-hot direction codes,
// FSM state encoding and direction helpers.
package snake_pkg;

  localparam int unsigned DIR_W = 5;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_NONE  = 5'b00000;
  localparam dir_t DIR_RIGHT = 5'b00001;
  localparam dir_t DIR_DOWN  = 5'b00010;
  localparam dir_t DIR_LEFT  = 5'b00100;
  localparam dir_t DIR_UP    = 5'b01000;
  localparam dir_t DIR_STOP  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // Exact reverse of a move code; anything else has no opposite.
  function automatic dir_t opposite_dir(input dir_t d);
    dir_t r;
    case (d)
      DIR_RIGHT: r = DIR_LEFT;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_DOWN:  r = DIR_UP;
      DIR_UP:    r = DIR_DOWN;
      default:   r = DIR_NONE;
    endcase
    return r;
  endfunction

  // Only the four single-bit movement codes move; everything else means stop.
  function automatic logic is_move_code(input dir_t d);
    return (d == DIR_RIGHT) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_UP);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick generator: counts 0..TICK_CYCLES-1 and pulses on the wrap cycle;
// the count freezes while hold is high.
module snake_tick_gen #(
  parameter int unsigned TICK_CYCLES = 15165696
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_c = !hold && (cnt_q == CNT_LAST);

endmodule

// File: rtl/snake_mover.sv
// Snake motion engine: head plus growable body advancing one cell per tick,
// with reversal rejection and wall/self collision. SNAKE_WRAP_EN wraps walls.
module snake_mover
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W      = 64,
  parameter int unsigned GRID_H      = 48,
  parameter int unsigned X_W         = 7,
  parameter int unsigned Y_W         = 6,
  parameter int unsigned MAX_LEN     = 15,
  parameter int unsigned TICK_CYCLES = 15165696,
  parameter int unsigned INIT_X      = 32,
  parameter int unsigned INIT_Y      = 24,
  localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DIR_W-1:0]       direction,
  input  logic                   grow,
  output logic [X_W-1:0]         head_x,
  output logic [Y_W-1:0]         head_y,
  output logic [MAX_LEN*X_W-1:0] body_x,
  output logic [MAX_LEN*Y_W-1:0] body_y,
  output logic [LEN_W-1:0]       length,
  output logic                   step,
  output logic                   dead
);

  state_e           state_q, state_d;
  dir_t             cur_dir_q, cur_dir_d;
  logic [X_W-1:0]   head_x_q, head_x_d;
  logic [Y_W-1:0]   head_y_q, head_y_d;
  logic [X_W-1:0]   body_x_q [MAX_LEN];
  logic [X_W-1:0]   body_x_d [MAX_LEN];
  logic [Y_W-1:0]   body_y_q [MAX_LEN];
  logic [Y_W-1:0]   body_y_d [MAX_LEN];
  logic [LEN_W-1:0] len_q, len_d;
  logic             grow_pend_q, grow_pend_d;
  logic             step_q, step_d;
  logic             dead_q, dead_d;

  logic             tick_c;
  logic             move_code_c;
  logic             dir_ok_c;
  logic [X_W:0]     nx_w;
  logic [Y_W:0]     ny_w;
  logic             wall_x_c, wall_y_c, wall_c;
  logic [X_W-1:0]   nh_x;
  logic [Y_W-1:0]   nh_y;
  logic             grow_eff_c;
  logic [LEN_W-1:0] chk_len_c;
  logic [MAX_LEN-1:0] hit_c;
  logic             collide_c;

  snake_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .hold   (state_q == ST_DEAD),
    .tick_c (tick_c)
  );

  // Direction sample: reversal is only rejected once a body exists.
  always_comb begin
    move_code_c = is_move_code(direction);
    dir_ok_c    = move_code_c &&
                  !((len_q != '0) && (direction == opposite_dir(cur_dir_q)));
    cur_dir_d   = dir_ok_c ? direction : cur_dir_q;
  end

  // Candidate head one bit wider so that 0-1 shows up as negative.
  always_comb begin
    nx_w = {1'b0, head_x_q};
    ny_w = {1'b0, head_y_q};
    case (cur_dir_d)
      DIR_RIGHT: nx_w = {1'b0, head_x_q} + (X_W+1)'(1);
      DIR_LEFT:  nx_w = {1'b0, head_x_q} - (X_W+1)'(1);
      DIR_DOWN:  ny_w = {1'b0, head_y_q} + (Y_W+1)'(1);
      DIR_UP:    ny_w = {1'b0, head_y_q} - (Y_W+1)'(1);
      default:   ;
    endcase
    wall_x_c = ($signed(nx_w) < $signed((X_W+1)'(0))) ||
               ($signed(nx_w) > $signed((X_W+1)'(GRID_W - 1)));
    wall_y_c = ($signed(ny_w) < $signed((Y_W+1)'(0))) ||
               ($signed(ny_w) > $signed((Y_W+1)'(GRID_H - 1)));
`ifdef SNAKE_WRAP_EN
    wall_c = 1'b0;
    if (nx_w[X_W])     nh_x = X_W'(GRID_W - 1);
    else if (wall_x_c) nh_x = '0;
    else               nh_x = X_W'(nx_w);
    if (ny_w[Y_W])     nh_y = Y_W'(GRID_H - 1);
    else if (wall_y_c) nh_y = '0;
    else               nh_y = Y_W'(ny_w);
`else
    wall_c = wall_x_c || wall_y_c;
    nh_x   = X_W'(nx_w);
    nh_y   = Y_W'(ny_w);
`endif
  end

  // The tail slot vacates this move unless the snake is growing.
  always_comb begin
    grow_eff_c = grow_pend_q && (len_q < LEN_W'(MAX_LEN));
    if (grow_eff_c)        chk_len_c = len_q;
    else if (len_q == '0)  chk_len_c = '0;
    else                   chk_len_c = len_q - LEN_W'(1);
  end

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_hit
    assign hit_c[i] = (LEN_W'(i) < chk_len_c) &&
                      (body_x_q[i] == nh_x) && (body_y_q[i] == nh_y);
  end

  assign collide_c = wall_c || (|hit_c);

  always_comb begin
    state_d     = state_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    body_x_d    = body_x_q;
    body_y_d    = body_y_q;
    len_d       = len_q;
    grow_pend_d = grow_pend_q | grow;
    step_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (move_code_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tick_c && move_code_c) begin
          if (collide_c) begin
            state_d = ST_DEAD;
          end else begin
            head_x_d    = nh_x;
            head_y_d    = nh_y;
            body_x_d[0] = head_x_q;
            body_y_d[0] = head_y_q;
            for (int i = 1; i < MAX_LEN; i++) begin
              body_x_d[i] = body_x_q[i-1];
              body_y_d[i] = body_y_q[i-1];
            end
            if (grow_eff_c) len_d = len_q + LEN_W'(1);
            for (int i = 0; i < MAX_LEN; i++) begin
              if (LEN_W'(i) >= len_d) begin
                body_x_d[i] = '0;
                body_y_d[i] = '0;
              end
            end
            grow_pend_d = grow;
            step_d      = 1'b1;
          end
        end
      end
      ST_DEAD: ;
      default: state_d = ST_IDLE;
    endcase
    dead_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_dir_q   <= DIR_NONE;
      head_x_q    <= X_W'(INIT_X);
      head_y_q    <= Y_W'(INIT_Y);
      body_x_q    <= '{default: '0};
      body_y_q    <= '{default: '0};
      len_q       <= '0;
      grow_pend_q <= 1'b0;
      step_q      <= 1'b0;
      dead_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_dir_q   <= cur_dir_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      body_x_q    <= body_x_d;
      body_y_q    <= body_y_d;
      len_q       <= len_d;
      grow_pend_q <= grow_pend_d;
      step_q      <= step_d;
      dead_q      <= dead_d;
    end
  end

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_pack
    assign body_x[i*X_W +: X_W] = body_x_q[i];
    assign body_y[i*Y_W +: Y_W] = body_y_q[i];
  end

  assign head_x = head_x_q;
  assign head_y = head_y_q;
  assign length = len_q;
  assign step   = step_q;
  assign dead   = dead_q;

endmodule

// File: tb/tb_snake_mover.sv
// Directed self-checking bench for snake_mover with a 4-cycle tick.
module tb_snake_mover;
  import snake_pkg::*;

  localparam int unsigned X_W     = 7;
  localparam int unsigned Y_W     = 6;
  localparam int unsigned MAX_LEN = 15;
  localparam int unsigned LEN_W   = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [4:0]             direction = DIR_NONE;
  logic                   grow = 1'b0;
  logic [X_W-1:0]         head_x;
  logic [Y_W-1:0]         head_y;
  logic [MAX_LEN*X_W-1:0] body_x;
  logic [MAX_LEN*Y_W-1:0] body_y;
  logic [LEN_W-1:0]       length;
  logic                   step;
  logic                   dead;

  int checks = 0;
  int failures = 0;

  snake_mover #(
    .GRID_W(64), .GRID_H(48), .X_W(X_W), .Y_W(Y_W), .MAX_LEN(MAX_LEN),
    .TICK_CYCLES(4), .INIT_X(32), .INIT_Y(24)
  ) dut (
    .clk(clk), .reset(reset), .direction(direction), .grow(grow),
    .head_x(head_x), .head_y(head_y), .body_x(body_x), .body_y(body_y),
    .length(length), .step(step), .dead(dead)
  );

  always #5 clk = ~clk;

  // Leaves reset asserted at a falling edge; caller releases it.
  task automatic do_reset();
    reset = 1'b1;
    direction = DIR_NONE;
    grow = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
  endtask

  task automatic wait_step(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (step === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: step got=0 exp=1 (timeout)", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({head_x, head_y, length, step, dead} !== {7'd32, 6'd24, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got=%h exp=%h",
               {head_x, head_y, length, step, dead}, {7'd32, 6'd24, 4'd0, 1'b0, 1'b0});
    end
    checks++;
    if ((body_x !== '0) || (body_y !== '0)) begin
      failures++;
      $display("FAIL reset_body: got x=%h y=%h exp=0", body_x, body_y);
    end
  endtask

  task automatic test_run_right();
    int steps = 0;
    do_reset();
    direction = DIR_RIGHT;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
    end
    checks++;
    if (steps != 3) begin
      failures++;
      $display("FAIL run_step_count: got=%0d exp=3", steps);
    end
    checks++;
    if ({head_x, head_y, length, dead} !== {7'd35, 6'd24, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL run_right_head: got x=%0d y=%0d len=%0d dead=%0d exp x=35 y=24 len=0 dead=0",
               head_x, head_y, length, dead);
    end
  endtask

  task automatic test_grow();
    do_reset();
    direction = DIR_RIGHT;
    grow = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    grow = 1'b0;
    wait_step("grow_move1");
    wait_step("grow_move2");
    checks++;
    if ({head_x, head_y, length} !== {7'd34, 6'd24, 4'd1}) begin
      failures++;
      $display("FAIL grow_head: got x=%0d y=%0d len=%0d exp x=34 y=24 len=1", head_x, head_y, length);
    end
    checks++;
    if ({body_x[6:0], body_y[5:0], body_x[13:7], body_y[11:6]} !== {7'd33, 6'd24, 7'd0, 6'd0}) begin
      failures++;
      $display("FAIL grow_body: got s0=(%0d,%0d) s1=(%0d,%0d) exp s0=(33,24) s1=(0,0)",
               body_x[6:0], body_y[5:0], body_x[13:7], body_y[11:6]);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    direction = DIR_RIGHT;
    grow = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    grow = 1'b0;
    wait_step("rev_grow1");
    pulse_grow();
    wait_step("rev_grow2");
    direction = DIR_LEFT;
    wait_step("rev_ignored_move");
    checks++;
    if ({head_x, head_y, length} !== {7'd35, 6'd24, 4'd2}) begin
      failures++;
      $display("FAIL reversal_ignored: got x=%0d y=%0d len=%0d exp x=35 y=24 len=2", head_x, head_y, length);
    end
    do_reset();
    direction = DIR_RIGHT;
    reset = 1'b0;
    wait_step("rev0_first");
    direction = DIR_LEFT;
    wait_step("rev0_back");
    checks++;
    if ({head_x, head_y, length} !== {7'd32, 6'd24, 4'd0}) begin
      failures++;
      $display("FAIL reversal_len0: got x=%0d y=%0d len=%0d exp x=32 y=24 len=0", head_x, head_y, length);
    end
  endtask

  task automatic test_stop();
    int steps = 0;
    do_reset();
    direction = DIR_RIGHT;
    reset = 1'b0;
    wait_step("stop_first");
    direction = DIR_STOP;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
    end
    direction = 5'b00011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
    end
    checks++;
    if ((steps != 0) || (head_x !== 7'd33)) begin
      failures++;
      $display("FAIL stop_pause: got steps=%0d x=%0d exp steps=0 x=33", steps, head_x);
    end
    direction = DIR_RIGHT;
    wait_step("stop_resume");
    checks++;
    if ({head_x, head_y} !== {7'd34, 6'd24}) begin
      failures++;
      $display("FAIL stop_resume_head: got x=%0d y=%0d exp x=34 y=24", head_x, head_y);
    end
  endtask

  task automatic test_wall();
    int steps = 0;
    do_reset();
    direction = DIR_UP;
    reset = 1'b0;
    for (int i = 0; i < 14; i++) wait_step("wall_up");
    direction = DIR_RIGHT;
    for (int i = 0; i < 31; i++) wait_step("wall_right");
    checks++;
    if ({head_x, head_y, dead} !== {7'd63, 6'd10, 1'b0}) begin
      failures++;
      $display("FAIL wall_approach: got x=%0d y=%0d dead=%0d exp x=63 y=10 dead=0", head_x, head_y, dead);
    end
`ifdef SNAKE_WRAP_EN
    wait_step("wall_wrap_move");
    checks++;
    if ({head_x, head_y, dead} !== {7'd0, 6'd10, 1'b0}) begin
      failures++;
      $display("FAIL wall_wrap: got x=%0d y=%0d dead=%0d exp x=0 y=10 dead=0", head_x, head_y, dead);
    end
`else
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
    end
    checks++;
    if ({head_x, head_y, dead} !== {7'd63, 6'd10, 1'b1} || steps != 0) begin
      failures++;
      $display("FAIL wall_death: got x=%0d y=%0d dead=%0d steps=%0d exp x=63 y=10 dead=1 steps=0",
               head_x, head_y, dead, steps);
    end
`endif
  endtask

  task automatic test_self_collision();
    int steps = 0;
    do_reset();
    direction = DIR_RIGHT;
    grow = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    grow = 1'b0;
    wait_step("self_grow0");
    for (int i = 0; i < 3; i++) begin
      pulse_grow();
      wait_step("self_grow");
    end
    checks++;
    if ({head_x, head_y, length} !== {7'd36, 6'd24, 4'd4}) begin
      failures++;
      $display("FAIL self_setup: got x=%0d y=%0d len=%0d exp x=36 y=24 len=4", head_x, head_y, length);
    end
    direction = DIR_DOWN;
    wait_step("self_down");
    direction = DIR_LEFT;
    wait_step("self_left");
    checks++;
    if ({head_x, head_y, dead} !== {7'd35, 6'd25, 1'b0}) begin
      failures++;
      $display("FAIL self_loop: got x=%0d y=%0d dead=%0d exp x=35 y=25 dead=0", head_x, head_y, dead);
    end
    direction = DIR_UP;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
    end
    checks++;
    if ({head_x, head_y, length, dead} !== {7'd35, 6'd25, 4'd4, 1'b1} || steps != 0) begin
      failures++;
      $display("FAIL self_death: got x=%0d y=%0d len=%0d dead=%0d steps=%0d exp x=35 y=25 len=4 dead=1 steps=0",
               head_x, head_y, length, dead, steps);
    end
    direction = DIR_RIGHT;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
    end
    checks++;
    if ({head_x, head_y, dead} !== {7'd35, 6'd25, 1'b1} || steps != 0 || body_x[6:0] !== 7'd36) begin
      failures++;
      $display("FAIL dead_frozen: got x=%0d y=%0d dead=%0d steps=%0d s0x=%0d exp x=35 y=25 dead=1 steps=0 s0x=36",
               head_x, head_y, dead, steps, body_x[6:0]);
    end
  endtask

  task automatic test_max_len_and_reset();
    int wait_cycles = 0;
    bit seen = 1'b0;
    do_reset();
    direction = DIR_RIGHT;
    grow = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    grow = 1'b0;
    wait_step("max_grow0");
    for (int i = 0; i < 15; i++) begin
      pulse_grow();
      wait_step("max_grow");
    end
    checks++;
    if ({head_x, head_y, length} !== {7'd48, 6'd24, 4'd15}) begin
      failures++;
      $display("FAIL max_len: got x=%0d y=%0d len=%0d exp x=48 y=24 len=15", head_x, head_y, length);
    end
    checks++;
    if ({body_x[104:98], body_y[89:84]} !== {7'd33, 6'd24}) begin
      failures++;
      $display("FAIL max_tail: got (%0d,%0d) exp (33,24)", body_x[104:98], body_y[89:84]);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({head_x, head_y, length, step, dead} !== {7'd32, 6'd24, 4'd0, 1'b0, 1'b0} || body_x !== '0) begin
      failures++;
      $display("FAIL midtick_reset: got x=%0d y=%0d len=%0d step=%0d dead=%0d exp x=32 y=24 len=0 step=0 dead=0",
               head_x, head_y, length, step, dead);
    end
    reset = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      wait_cycles++;
      if (step === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || wait_cycles != 4 || head_x !== 7'd33) begin
      failures++;
      $display("FAIL midtick_restart: got seen=%0d cycles=%0d x=%0d exp seen=1 cycles=4 x=33",
               seen, wait_cycles, head_x);
    end
  endtask

  initial begin
    test_reset();
    test_run_right();
    test_grow();
    test_reversal();
    test_stop();
    test_wall();
    test_self_collision();
    test_max_len_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
